// File: rtl/tdc_fifo_readout_if.sv
// Byte stream from the TDC readout serializer toward the readout link bridge.
interface tdc_fifo_readout_if;
    logic [7:0] o_byte;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;

    modport master (
        output o_byte,
        output o_valid,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_byte,
        input  o_valid,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/tdc_fifo_readout.sv
// Read side of the TDC event FIFO. Pops one event word at a time, prefixes
// the sync nibble and streams it MSB-first as a 9-byte frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable and a non-empty FIFO; pops when both hold
// CAPTURE | popped word is on fifo_data; load shift register and fields
// SEND    | present bytes 0..8 on the stream, advance on each handshake
module tdc_fifo_readout #(
    parameter int         DATA_LENGTH = 68,
    parameter int         CHAN_W      = 4,
    parameter int         TOT_W       = 16,
    parameter int         TS_W        = 48,
    parameter logic [3:0] SYNC        = 4'hA,
    parameter int         COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_LENGTH-1:0] fifo_data,
    output logic                   fifo_read,
    tdc_fifo_readout_if.master     stream,
    output logic [CHAN_W-1:0]      o_chan,
    output logic [TOT_W-1:0]       o_tot,
    output logic [TS_W-1:0]        o_ts,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] frames_sent
);

    // Frame is the sync nibble followed by the full FIFO word.
    localparam int         FRAME_W     = DATA_LENGTH + 4;
    localparam int         FRAME_BYTES = FRAME_W / 8;
    localparam logic [3:0] LAST_IDX    = 4'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [FRAME_W-1:0]   shift_q;
    logic [3:0]           idx_q;
    logic                 valid_q;
    logic                 valid_nxt;
    logic                 last_q;
    logic                 last_nxt;
    logic                 pop;
    logic                 accept;
    logic                 frame_done;

    assign accept     = (state == SEND) && valid_q && stream.i_ready;
    assign frame_done = accept && (idx_q == LAST_IDX);

    // Reset masks the pop so a held reset never drains the FIFO.
    assign fifo_read      = pop && reset;
    assign busy           = (state != IDLE);
    assign stream.o_byte  = shift_q[FRAME_W-1 -: 8];
    assign stream.o_valid = valid_q;
    assign stream.o_last  = last_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, pop strobe and next values of the registered stream flags.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (enable && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                valid_nxt = 1'b1;
                last_nxt  = 1'b0;
                state_nxt = SEND;
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        last_nxt = (idx_q == LAST_IDX - 4'd1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // Registered stream flags; they only move on a handshake, so they hold under back-pressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
        end
    end

    // Shift register, byte index and decoded fields of the word in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            o_chan  <= '0;
            o_tot   <= '0;
            o_ts    <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    shift_q <= {SYNC, fifo_data};
                    idx_q   <= '0;
                    o_chan  <= fifo_data[DATA_LENGTH-1 -: CHAN_W];
                    o_tot   <= fifo_data[TS_W +: TOT_W];
                    o_ts    <= fifo_data[TS_W-1:0];
                end
                SEND: begin
                    if (accept) begin
                        shift_q <= {shift_q[FRAME_W-9:0], 8'h00};
                        idx_q   <= idx_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completed-frame counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frames_sent <= '0;
        end else if (frame_done && (frames_sent != '1)) begin
            frames_sent <= frames_sent + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tdc_fifo_readout.sv
// Bench for tdc_fifo_readout: a queue-backed FIFO model feeds two instances
// (16-bit and 2-bit frame counters) and accepted bytes are compared against
// frames rebuilt from the words popped.
module tb_tdc_fifo_readout;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [67:0] fifo_data;
    logic        i_ready;

    logic        fifo_read_w, fifo_read_s;
    logic [3:0]  o_chan_w, o_chan_s;
    logic [15:0] o_tot_w, o_tot_s;
    logic [47:0] o_ts_w, o_ts_s;
    logic        busy_w, busy_s;
    logic [15:0] frames_w;
    logic [1:0]  frames_s;

    tdc_fifo_readout_if bus_w ();
    tdc_fifo_readout_if bus_s ();

    assign bus_w.i_ready = i_ready;
    assign bus_s.i_ready = i_ready;

    always #5 clk = ~clk;

    tdc_fifo_readout dut_w (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read(fifo_read_w), .stream(bus_w),
        .o_chan(o_chan_w), .o_tot(o_tot_w), .o_ts(o_ts_w),
        .busy(busy_w), .frames_sent(frames_w)
    );

    tdc_fifo_readout #(.COUNT_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read(fifo_read_s), .stream(bus_s),
        .o_chan(o_chan_s), .o_tot(o_tot_s), .o_ts(o_ts_s),
        .busy(busy_s), .frames_sent(frames_s)
    );

    int checks;
    int errors;
    int cyc;
    int n_frames;

    logic [67:0] q[$];
    logic [67:0] popped[$];
    logic [8:0]  acc[$];
    int          acc_cyc[$];
    int          rd_cyc[$];
    int          valid_cnt;
    int          first_valid;
    int          hold_viol;
    int          rd_viol;
    int          diff_cnt;
    bit          prev_v, prev_rdy, prev_rd, prev_l;
    logic [7:0]  prev_b;

    function automatic logic [67:0] rand_word();
        logic [31:0] a, b, c, d;
        a = $urandom(); b = $urandom(); c = $urandom(); d = $urandom();
        return {a[3:0], b[15:0], c, d[15:0]};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [67:0] w, input int k);
        logic [71:0] f;
        f = {4'hA, w};
        return f[71 - 8*k -: 8];
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic clear_logs();
        popped.delete(); acc.delete(); acc_cyc.delete(); rd_cyc.delete();
        valid_cnt = 0; first_valid = -1; hold_viol = 0; rd_viol = 0; diff_cnt = 0;
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic cycle();
        bit rd_s, v_s, l_s;
        logic [7:0] b_s;
        fifo_empty = (q.size() == 0);
        #1;
        rd_s = fifo_read_w; v_s = bus_w.o_valid; l_s = bus_w.o_last; b_s = bus_w.o_byte;
        if (rd_s && (prev_rd || v_s || !enable || fifo_empty)) rd_viol++;
        if (prev_v && !prev_rdy && (!v_s || b_s !== prev_b || l_s !== prev_l)) hold_viol++;
        if (fifo_read_s !== rd_s || bus_s.o_valid !== v_s || bus_s.o_byte !== b_s ||
            bus_s.o_last !== l_s || busy_s !== busy_w || o_chan_s !== o_chan_w ||
            o_tot_s !== o_tot_w || o_ts_s !== o_ts_w) diff_cnt++;
        if (v_s) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (v_s && i_ready) begin
            acc.push_back({l_s, b_s});
            acc_cyc.push_back(cyc);
        end
        if (rd_s) rd_cyc.push_back(cyc);
        prev_v = v_s; prev_rdy = i_ready; prev_rd = rd_s; prev_l = l_s; prev_b = b_s;
        @(posedge clk);
        @(negedge clk);
        if (rd_s && q.size() > 0) begin
            fifo_data = q.pop_front();
            popped.push_back(fifo_data);
        end else begin
            fifo_data = rand_word();
        end
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1; fifo_empty = 1'b0; i_ready = 1'($urandom()); fifo_data = rand_word();
            #1;
            checks++;
            if (fifo_read_w !== 1'b0) begin
                errors++; $display("FAIL reset_fifo_read got %0b want 0", fifo_read_w);
            end
            @(posedge clk); @(negedge clk);
        end
        checks++; if (bus_w.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus_w.o_valid); end
        checks++; if (bus_w.o_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", bus_w.o_last); end
        checks++; if (bus_w.o_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %0h want 0", bus_w.o_byte); end
        checks++; if (busy_w !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_w); end
        checks++; if ({o_chan_w, o_tot_w, o_ts_w} !== 68'h0) begin errors++; $display("FAIL reset_fields got %0h want 0", {o_chan_w, o_tot_w, o_ts_w}); end
        checks++; if (frames_w !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d want 0", frames_w); end
        checks++; if (frames_s !== 2'd0) begin errors++; $display("FAIL reset_frames_small got %0d want 0", frames_s); end
        reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; i_ready = 1'b1;
        n_frames = 0; prev_v = 0; prev_rd = 0;
    endtask

    task automatic test_single();
        logic [7:0] exp_b [9] = '{8'hA3, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD};
        logic [8:0] e;
        int k;
        clear_logs();
        enable = 1'b1; i_ready = 1'b1;
        q.push_back({4'h3, 16'h1234, 48'h0000_0000_ABCD});
        k = 0;
        while (acc.size() < 9 && k < 40) begin cycle(); k++; end
        cycle();
        n_frames++;
        checks++; if (acc.size() != 9) begin errors++; $display("FAIL single_timeout got %0d bytes want 9", acc.size()); end
        checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL single_pops got %0d want 1", rd_cyc.size()); end
        for (int i = 0; i < 9 && i < acc.size(); i++) begin
            e = acc[i];
            checks++;
            if (e !== {(i == 8), exp_b[i]}) begin
                errors++; $display("FAIL single_byte%0d got %0h want %0h", i, e, {(i == 8), exp_b[i]});
            end
        end
        checks++; if (valid_cnt != 9) begin errors++; $display("FAIL single_valid_cycles got %0d want 9", valid_cnt); end
        if (rd_cyc.size() > 0) begin
            checks++;
            if (first_valid != rd_cyc[0] + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", first_valid, rd_cyc[0] + 2); end
        end
        checks++; if (frames_w !== 16'(n_frames)) begin errors++; $display("FAIL single_frames got %0d want %0d", frames_w, n_frames); end
        checks++; if ({o_chan_w, o_tot_w, o_ts_w} !== {4'h3, 16'h1234, 48'hABCD}) begin
            errors++; $display("FAIL single_fields got %0h want %0h", {o_chan_w, o_tot_w, o_ts_w}, {4'h3, 16'h1234, 48'hABCD});
        end
    endtask

    task automatic test_backpressure();
        logic [67:0] w;
        logic [8:0]  e;
        int k, stall;
        clear_logs();
        w = rand_word();
        w[67:48] = {4'h5, 16'h1234};
        q.push_back(w);
        k = 0; stall = 0;
        while (acc.size() < 9 && k < 60) begin
            if (bus_w.o_valid && acc.size() == 2 && stall < 5) begin
                i_ready = 1'b0; stall++;
                checks++;
                if (bus_w.o_byte !== 8'h34) begin errors++; $display("FAIL bp_stall_byte got %0h want 34", bus_w.o_byte); end
            end else begin
                i_ready = 1'b1;
            end
            cycle(); k++;
        end
        i_ready = 1'b1;
        n_frames++;
        checks++; if (acc.size() != 9) begin errors++; $display("FAIL bp_timeout got %0d bytes want 9", acc.size()); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d violations want 0", hold_viol); end
        for (int i = 0; i < acc.size(); i++) begin
            e = acc[i];
            checks++;
            if (e !== {(i == 8), frame_byte(w, i)}) begin errors++; $display("FAIL bp_byte%0d got %0h want %0h", i, e, {(i == 8), frame_byte(w, i)}); end
        end
        if (acc.size() == 9 && rd_cyc.size() > 0) begin
            checks++;
            if (acc_cyc[8] - rd_cyc[0] + 1 != 16) begin errors++; $display("FAIL bp_frame_time got %0d want 16", acc_cyc[8] - rd_cyc[0] + 1); end
        end
        checks++; if (frames_w !== 16'(n_frames)) begin errors++; $display("FAIL bp_frames got %0d want %0d", frames_w, n_frames); end
    endtask

    task automatic test_back_to_back();
        logic [67:0] words [3];
        logic [8:0]  e;
        int k;
        clear_logs();
        i_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin words[i] = rand_word(); q.push_back(words[i]); end
        k = 0;
        while (acc.size() < 27 && k < 80) begin cycle(); k++; end
        n_frames += 3;
        checks++; if (acc.size() != 27) begin errors++; $display("FAIL b2b_timeout got %0d bytes want 27", acc.size()); end
        checks++; if (rd_cyc.size() != 3) begin errors++; $display("FAIL b2b_pops got %0d want 3", rd_cyc.size()); end
        for (int i = 1; i < rd_cyc.size(); i++) begin
            checks++;
            if (rd_cyc[i] - rd_cyc[i-1] != 11) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 11", i, rd_cyc[i] - rd_cyc[i-1]); end
        end
        for (int i = 0; i < acc.size() && i < 27; i++) begin
            e = acc[i];
            checks++;
            if (e !== {(i % 9 == 8), frame_byte(words[i / 9], i % 9)}) begin
                errors++; $display("FAIL b2b_byte%0d got %0h want %0h", i, e, {(i % 9 == 8), frame_byte(words[i / 9], i % 9)});
            end
        end
        checks++; if (frames_w !== 16'(n_frames)) begin errors++; $display("FAIL b2b_frames got %0d want %0d", frames_w, n_frames); end
        checks++; if ({o_chan_w, o_tot_w, o_ts_w} !== words[2]) begin errors++; $display("FAIL b2b_fields got %0h want %0h", {o_chan_w, o_tot_w, o_ts_w}, words[2]); end
    endtask

    task automatic test_reset_mid();
        logic [67:0] w2;
        logic [8:0]  e;
        int k;
        clear_logs();
        i_ready = 1'b1; enable = 1'b1;
        q.push_back(rand_word());
        k = 0;
        while (acc.size() < 4 && k < 30) begin cycle(); k++; end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin @(posedge clk); @(negedge clk); cyc++; end
        n_frames = 0;
        checks++; if (bus_w.o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", bus_w.o_valid); end
        checks++; if (busy_w !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy_w); end
        checks++; if (frames_w !== 16'd0) begin errors++; $display("FAIL rmid_frames got %0d want 0", frames_w); end
        reset = 1'b1; prev_v = 0; prev_rd = 0;
        clear_logs();
        w2 = rand_word();
        q.push_back(w2);
        k = 0;
        while (acc.size() < 9 && k < 40) begin cycle(); k++; end
        n_frames++;
        checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL rmid_fresh_pop got %0d want 1", rd_cyc.size()); end
        checks++; if (acc.size() != 9) begin errors++; $display("FAIL rmid_timeout got %0d bytes want 9", acc.size()); end
        for (int i = 0; i < acc.size(); i++) begin
            e = acc[i];
            checks++;
            if (e !== {(i == 8), frame_byte(w2, i)}) begin errors++; $display("FAIL rmid_byte%0d got %0h want %0h", i, e, {(i == 8), frame_byte(w2, i)}); end
        end
        checks++; if (frames_w !== 16'(n_frames)) begin errors++; $display("FAIL rmid_frames_after got %0d want %0d", frames_w, n_frames); end
    endtask

    task automatic test_saturation();
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        int k;
        reset = 1'b0;
        @(posedge clk); @(negedge clk); cyc++;
        reset = 1'b1; prev_v = 0; prev_rd = 0;
        n_frames = 0; i_ready = 1'b1; enable = 1'b1;
        for (int f = 0; f < 5; f++) begin
            clear_logs();
            q.push_back(rand_word());
            k = 0;
            while (acc.size() < 9 && k < 40) begin cycle(); k++; end
            n_frames++;
            checks++;
            if (int'(frames_s) != sat_exp[f]) begin errors++; $display("FAIL sat_small%0d got %0d want %0d", f, frames_s, sat_exp[f]); end
            checks++;
            if (frames_w !== 16'(n_frames)) begin errors++; $display("FAIL sat_wide%0d got %0d want %0d", f, frames_w, n_frames); end
        end
    endtask

    task automatic test_random();
        logic [67:0] words[$];
        logic [67:0] w;
        logic [8:0]  e;
        int n, k;
        clear_logs();
        n = 8; k = 0;
        while (k < 3000 && !(words.size() == n && q.size() == 0 && acc.size() >= 9 * n)) begin
            if (words.size() < n && $urandom_range(0, 3) == 0) begin
                w = rand_word(); words.push_back(w); q.push_back(w);
            end
            enable  = ($urandom_range(0, 7) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            cycle(); k++;
        end
        n_frames += n;
        i_ready = 1'b1;
        checks++; if (acc.size() != 9 * n) begin errors++; $display("FAIL rnd_timeout got %0d bytes want %0d", acc.size(), 9 * n); end
        checks++; if (popped.size() != n) begin errors++; $display("FAIL rnd_pops got %0d want %0d", popped.size(), n); end
        for (int i = 0; i < acc.size() && i < 9 * n; i++) begin
            e = acc[i];
            checks++;
            if (e !== {(i % 9 == 8), frame_byte(words[i / 9], i % 9)}) begin
                errors++; $display("FAIL rnd_byte%0d got %0h want %0h", i, e, {(i % 9 == 8), frame_byte(words[i / 9], i % 9)});
            end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL rnd_hold got %0d violations want 0", hold_viol); end
        checks++; if (rd_viol != 0) begin errors++; $display("FAIL rnd_pop_rules got %0d violations want 0", rd_viol); end
        checks++; if (diff_cnt != 0) begin errors++; $display("FAIL rnd_instances_differ got %0d cycles want 0", diff_cnt); end
        checks++; if (frames_w !== 16'(sat(n_frames, 65535))) begin errors++; $display("FAIL rnd_frames got %0d want %0d", frames_w, n_frames); end
        checks++; if (int'(frames_s) != sat(n_frames, 3)) begin errors++; $display("FAIL rnd_frames_small got %0d want %0d", frames_s, sat(n_frames, 3)); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; n_frames = 0;
        reset = 1'b0; enable = 1'b0; fifo_empty = 1'b1; i_ready = 1'b0; fifo_data = '0;
        prev_v = 0; prev_rdy = 0; prev_rd = 0; prev_l = 0; prev_b = '0;
        clear_logs();
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
